ps2_keycode_frontend: RTL and testbench



---
 rtl/ps2_keycode_frontend.sv | 125 ++++++++++++
 tb/tb_ps2_keycode_frontend.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_frontend.sv
// ps2_keycode_frontend: PS/2 device-to-host frame receiver feeding a set-2 prefix
// and modifier folder that emits 16-bit keycodes with a one-cycle strobe.
module ps2_keycode_frontend #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  scan_code,
   output logic        scan_parity,
   output logic        scan_busy,
   output logic        scan_rdy,
   output logic        scan_error,
   output logic [15:0] keycode,
   output logic        key_strobe
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    sr_q, sr_d;
   logic [7:0]    code_q, code_d;
   logic          par_q, par_d, rdy_q, rdy_d, err_q, err_d;
   logic          ext_q, ext_d, rel_q, rel_d, shift_q, shift_d, ctrl_q, ctrl_d, meta_q, meta_d;
   logic [15:0]   key_q, key_d;
   logic          strobe_q, strobe_d;
   logic          flip, fall, last, frame_ok, busy, timeout;

   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      // a differing sample run of FILTER_LEN flips the filtered level
      flip       = (clk_sync_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
      fcnt_d     = (clk_sync_q[1] == filt_q || flip) ? '0 : fcnt_q + 1'b1;
      filt_d     = flip ? ~filt_q : filt_q;
      fall       = flip & filt_q;
      busy       = bit_cnt_q != 4'd0;
      last       = fall && bit_cnt_q == 4'd10;
      // sr holds start..parity; the stop bit is the live sample on the last edge
      frame_ok   = !sr_q[0] && dat_sync_q[1] && (^sr_q[9:1]);
      timeout    = busy && !fall && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
      tcnt_d     = (!busy || fall || timeout) ? '0 : tcnt_q + 1'b1;
      bit_cnt_d  = (last || timeout) ? 4'd0 : fall ? bit_cnt_q + 4'd1 : bit_cnt_q;
      sr_d       = fall ? {dat_sync_q[1], sr_q[9:1]} : sr_q;
      code_d     = last ? sr_q[8:1] : code_q;
      par_d      = last ? sr_q[9] : par_q;
      rdy_d      = last & frame_ok;
      err_d      = (last & ~frame_ok) | timeout;
      ext_d      = ext_q;
      rel_d      = rel_q;
      shift_d    = shift_q;
      ctrl_d     = ctrl_q;
      meta_d     = meta_q;
      key_d      = key_q;
      strobe_d   = 1'b0;
      if (rdy_q) begin
         if (code_q == 8'hE0) ext_d = 1'b1;
         else if (code_q == 8'hF0) rel_d = 1'b1;
         else begin
            shift_d  = (code_q == 8'h12 || code_q == 8'h59) ? ~rel_q : shift_q;
            ctrl_d   = (code_q == 8'h14) ? ~rel_q : ctrl_q;
            meta_d   = (code_q == 8'h11) ? ~rel_q : meta_q;
            key_d    = {rel_q, ext_q, shift_d, ctrl_d, meta_d, 3'b000, code_q};
            strobe_d = 1'b1;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         tcnt_q     <= '0;
         bit_cnt_q  <= 4'd0;
         sr_q       <= '0;
         code_q     <= '0;
         par_q      <= 1'b0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         shift_q    <= 1'b0;
         ctrl_q     <= 1'b0;
         meta_q     <= 1'b0;
         key_q      <= '0;
         strobe_q   <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         tcnt_q     <= tcnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         code_q     <= code_d;
         par_q      <= par_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         shift_q    <= shift_d;
         ctrl_q     <= ctrl_d;
         meta_q     <= meta_d;
         key_q      <= key_d;
         strobe_q   <= strobe_d;
      end
   end

   assign scan_code   = code_q;
   assign scan_parity = par_q;
   assign scan_busy   = busy;
   assign scan_rdy    = rdy_q;
   assign scan_error  = err_q;
   assign keycode     = key_q;
   assign key_strobe  = strobe_q;
endmodule

// File: tb/tb_ps2_keycode_frontend.sv
// tb_ps2_keycode_frontend: drives PS/2 frames and checks scan and keycode outputs
// against a queue-based model of frame validity and prefix/modifier folding.
module tb_ps2_keycode_frontend;
   localparam int FL = 4, TO = 600, HALF = 20;
   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0]  scan_code;
   logic        scan_parity, scan_busy, scan_rdy, scan_error, key_strobe;
   logic [15:0] keycode;
   typedef struct {
      logic       err;
      logic       chk;
      logic [7:0] code;
      logic       par;
   } scan_t;
   scan_t       sq[$];
   logic [15:0] kq[$];
   int          checks = 0, errors = 0;
   logic        m_ext, m_rel, m_shift, m_ctrl, m_meta;
   logic [15:0] last_key = '0;
   logic        prev_rdy = 1'b0;

   ps2_keycode_frontend #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_code(scan_code), .scan_parity(scan_parity), .scan_busy(scan_busy),
      .scan_rdy(scan_rdy), .scan_error(scan_error), .keycode(keycode), .key_strobe(key_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset;
      {m_ext, m_rel, m_shift, m_ctrl, m_meta} = '0;
   endtask

   task automatic model_code(input logic [7:0] c);
      if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'hF0) m_rel = 1'b1;
      else begin
         if (c == 8'h12 || c == 8'h59) m_shift = !m_rel;
         if (c == 8'h14) m_ctrl = !m_rel;
         if (c == 8'h11) m_meta = !m_rel;
         kq.push_back({m_rel, m_ext, m_shift, m_ctrl, m_meta, 3'b000, c});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         cycles(HALF);
         ps2_clk = 1'b0;
         cycles(HALF);
         ps2_clk = 1'b1;
      end
      cycles(HALF);
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic [10:0] f;
      scan_t e;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      e.err = bad_par | bad_stop;
      e.chk = 1'b1;
      e.code = b;
      e.par = f[9];
      sq.push_back(e);
      if (!e.err) model_code(b);
      drive(f, 11);
   endtask

   task automatic partial(input logic [7:0] b, input int n);
      drive({1'b1, ~^b, b, 1'b0}, n);
   endtask

   task automatic drain(input string name, input int n);
      cycles(n);
      check({name, "_scan_pending"}, sq.size(), 0);
      check({name, "_key_pending"}, kq.size(), 0);
      check({name, "_busy_idle"}, scan_busy, 0);
      sq.delete();
      kq.delete();
   endtask

   always @(negedge clk) begin
      scan_t e;
      if (reset) begin
         last_key = '0;
         prev_rdy = 1'b0;
      end else begin
         if (scan_rdy || scan_error) begin
            if (sq.size() == 0) check("unexpected_scan_pulse", {scan_rdy, scan_error}, 0);
            else begin
               e = sq.pop_front();
               check("scan_error", scan_error, e.err);
               check("scan_rdy", scan_rdy, !e.err);
               if (e.chk) begin
                  check("scan_code", scan_code, e.code);
                  check("scan_parity", scan_parity, e.par);
               end
            end
         end
         if (key_strobe) begin
            check("strobe_after_rdy", prev_rdy, 1);
            if (kq.size() == 0) check("unexpected_strobe", key_strobe, 0);
            else check("keycode", keycode, kq.pop_front());
            last_key = keycode;
         end else check("keycode_hold", keycode, last_key);
         prev_rdy = scan_rdy;
      end
   end

   initial begin
      logic [7:0] pool [8];
      logic [7:0] c;
      pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h1C, 8'h75};
      model_reset();
      cycles(5);
      check("rst_scan_code", scan_code, 0);
      check("rst_scan_parity", scan_parity, 0);
      check("rst_scan_busy", scan_busy, 0);
      check("rst_scan_rdy", scan_rdy, 0);
      check("rst_scan_error", scan_error, 0);
      check("rst_keycode", keycode, 0);
      check("rst_key_strobe", key_strobe, 0);
      reset = 1'b0;
      cycles(5);
      send(8'h1C, 0, 0);
      drain("make_1c", 40);
      check("lit_001c", last_key, 16'h001C);
      check("lit_parity_1c", scan_parity, 0);
      send(8'hF0, 0, 0);
      send(8'h1C, 0, 0);
      drain("break_1c", 40);
      check("lit_801c", last_key, 16'h801C);
      send(8'hE0, 0, 0);
      send(8'hF0, 0, 0);
      send(8'h75, 0, 0);
      drain("ext_break", 40);
      check("lit_c075", last_key, 16'hC075);
      send(8'h75, 0, 0);
      drain("flags_cleared", 40);
      check("lit_0075", last_key, 16'h0075);
      send(8'h12, 0, 0);
      drain("shift_make", 40);
      check("lit_2012", last_key, 16'h2012);
      send(8'h1C, 0, 0);
      drain("shifted_key", 40);
      check("lit_201c", last_key, 16'h201C);
      send(8'hF0, 0, 0);
      send(8'h12, 0, 0);
      drain("shift_break", 40);
      check("lit_8012", last_key, 16'h8012);
      send(8'h1C, 0, 0);
      drain("unshifted", 40);
      check("lit_001c_b", last_key, 16'h001C);
      send(8'h1C, 1, 0);
      drain("bad_parity", 40);
      check("lit_bad_parity_bit", scan_parity, 1);
      send(8'h1C, 0, 1);
      drain("bad_stop", 40);
      sq.push_back('{err: 1'b1, chk: 1'b0, code: 8'h00, par: 1'b0});
      partial(8'h1C, 5);
      drain("timeout", TO + 100);
      send(8'h1C, 0, 0);
      drain("after_timeout", 40);
      check("lit_after_timeout", last_key, 16'h001C);
      send(8'hE0, 0, 0);
      drain("prefix_before_reset", 40);
      partial(8'h1C, 5);
      reset = 1'b1;
      model_reset();
      cycles(3);
      reset = 1'b0;
      cycles(20);
      check("reset_busy", scan_busy, 0);
      send(8'h1C, 0, 0);
      drain("after_reset", 40);
      check("lit_after_reset", last_key, 16'h001C);
      repeat (40) begin
         c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
         send(c, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
         drain("random", 40);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
